// File: rtl/delay_pipe_v.sv
// delay_pipe_v: multi-lane delay line with per-stage valid tags, stall, flush and occupancy count.
// Define DELAY_PIPE_V_DEPTH_SEL_EN for runtime depth load; otherwise depth is fixed at MAX_DEPTH.
module delay_pipe_v #(
   parameter int DWIDTH    = 12,
   parameter int LANES     = 2,
   parameter int MAX_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en_i,
   input  logic                             flush_i,
   input  logic                             valid_i,
   input  logic [LANES*DWIDTH-1:0]          data_i,
   output logic                             valid_o,
   output logic [LANES*DWIDTH-1:0]          data_o,
   input  logic                             depth_ld_i,
   input  logic [$clog2(MAX_DEPTH+1)-1:0]   depth_sel_i,
   output logic [$clog2(MAX_DEPTH+1)-1:0]   depth_o,
   output logic                             depth_err_o,
   output logic [$clog2(MAX_DEPTH+1)-1:0]   cnt_o,
   output logic                             empty_o
);

   localparam int WW = LANES * DWIDTH;
   localparam int CW = $clog2(MAX_DEPTH + 1);
   localparam logic [CW-1:0] C_MAX = CW'(MAX_DEPTH);

   logic [WW-1:0]        r_data [MAX_DEPTH];
   logic [MAX_DEPTH-1:0] r_vld;
   logic [CW-1:0]        r_cnt;
   logic                 w_vld_tap;
   logic [WW-1:0]        w_data_tap;
   logic                 w_clr_vld;

`ifdef DELAY_PIPE_V_DEPTH_SEL_EN
   logic [CW-1:0] r_depth;
   logic          r_err;
   logic          w_sel_ok;
   logic          w_ld_acc;

   assign w_sel_ok = (depth_sel_i != '0) && (depth_sel_i <= C_MAX);
   // flush empties the pipe this cycle, so it waives the occupancy condition
   assign w_ld_acc = depth_ld_i && w_sel_ok &&
                     (flush_i || ((r_cnt == '0) && !(en_i && valid_i)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_depth <= C_MAX;
         r_err   <= 1'b0;
      end else begin
         r_err <= depth_ld_i && !w_ld_acc;
         if (w_ld_acc) r_depth <= depth_sel_i;
      end
   end

   always_comb begin
      w_vld_tap  = 1'b0;
      w_data_tap = '0;
      for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
         if (r_depth == CW'(i + 1)) begin
            w_vld_tap  = r_vld[i];
            w_data_tap = r_data[i];
         end
      end
   end

   assign w_clr_vld   = w_ld_acc;
   assign depth_o     = r_depth;
   assign depth_err_o = r_err;
`else
   logic w_unused_depth;
   assign w_unused_depth = ^{depth_ld_i, depth_sel_i};
   assign w_vld_tap      = r_vld[MAX_DEPTH-1];
   assign w_data_tap     = r_data[MAX_DEPTH-1];
   assign w_clr_vld      = 1'b0;
   assign depth_o        = C_MAX;
   assign depth_err_o    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int unsigned i = 0; i < MAX_DEPTH; i++) r_data[i] <= '0;
      end else if (flush_i) begin
         r_vld <= '0;
         for (int unsigned i = 0; i < MAX_DEPTH; i++) r_data[i] <= '0;
      end else begin
         if (en_i) begin
            r_data[0] <= data_i;
            for (int unsigned i = 1; i < MAX_DEPTH; i++) r_data[i] <= r_data[i-1];
         end
         // a depth change leaves no live word behind, so every tag can be dropped
         if (w_clr_vld) begin
            r_vld <= '0;
         end else if (en_i) begin
            r_vld[0] <= valid_i;
            for (int unsigned i = 1; i < MAX_DEPTH; i++) r_vld[i] <= r_vld[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (flush_i) begin
         r_cnt <= '0;
      end else if (en_i) begin
         r_cnt <= r_cnt + CW'(valid_i) - CW'(w_vld_tap);
      end
   end

   assign valid_o = w_vld_tap;
   assign data_o  = w_vld_tap ? w_data_tap : '0;
   assign cnt_o   = r_cnt;
   assign empty_o = (r_cnt == '0);

endmodule

// File: tb/tb_delay_pipe_v.sv
// Self-checking bench for delay_pipe_v: scoreboard queue of in-flight words with enabled-edge ages.
module tb_delay_pipe_v;

   localparam int DWIDTH    = 12;
   localparam int LANES     = 2;
   localparam int MAX_DEPTH = 8;
   localparam int WW        = LANES * DWIDTH;
   localparam int CW        = $clog2(MAX_DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en_i, flush_i, valid_i, depth_ld_i;
   logic [WW-1:0] data_i;
   logic [CW-1:0] depth_sel_i;
   logic          valid_o, depth_err_o, empty_o;
   logic [WW-1:0] data_o;
   logic [CW-1:0] depth_o, cnt_o;

   always #5 clk = ~clk;

   delay_pipe_v #(.DWIDTH(DWIDTH), .LANES(LANES), .MAX_DEPTH(MAX_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .flush_i(flush_i),
      .valid_i(valid_i), .data_i(data_i), .valid_o(valid_o), .data_o(data_o),
      .depth_ld_i(depth_ld_i), .depth_sel_i(depth_sel_i), .depth_o(depth_o),
      .depth_err_o(depth_err_o), .cnt_o(cnt_o), .empty_o(empty_o)
   );

   typedef struct {
      logic [WW-1:0] d;
      int            ticks;
   } ent_t;

   ent_t q[$];
   int   depth_m  = MAX_DEPTH;
   logic err_m    = 1'b0;
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] mk(input int k);
      mk = {DWIDTH'(k + 256), DWIDTH'(k)};
   endfunction

   task automatic check_outputs(input string tag);
      logic          ev;
      logic [WW-1:0] ed;
      ev = 1'b0;
      ed = '0;
      if (q.size() > 0) begin
         if (q[0].ticks == depth_m) begin
            ev = 1'b1;
            ed = q[0].d;
         end
      end
      chk({tag, ".valid"}, 32'(valid_o), 32'(ev));
      chk({tag, ".data"},  32'(data_o),  32'(ed));
      chk({tag, ".cnt"},   32'(cnt_o),   32'(q.size()));
      chk({tag, ".empty"}, 32'(empty_o), 32'(q.size() == 0));
      chk({tag, ".depth"}, 32'(depth_o), 32'(depth_m));
      chk({tag, ".err"},   32'(depth_err_o), 32'(err_m));
   endtask

   task automatic step(input logic en, input logic fl, input logic v, input logic [WW-1:0] d,
                       input logic ld = 1'b0, input logic [CW-1:0] sel = '0,
                       input string tag = "step");
      logic acc;
      en_i        = en;
      flush_i     = fl;
      valid_i     = v;
      data_i      = d;
      depth_ld_i  = ld;
      depth_sel_i = sel;
      acc         = 1'b0;
`ifdef DELAY_PIPE_V_DEPTH_SEL_EN
      acc = ld && (sel >= 1) && (int'(sel) <= MAX_DEPTH) && (fl || ((q.size() == 0) && !(en && v)));
`endif
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else if (en) begin
         if (q.size() > 0) begin
            if (q[0].ticks == depth_m) void'(q.pop_front());
         end
         foreach (q[i]) q[i].ticks++;
         if (v) q.push_back('{d: d, ticks: 1});
      end
`ifdef DELAY_PIPE_V_DEPTH_SEL_EN
      err_m = ld && !acc;
      if (acc) depth_m = int'(sel);
`else
      err_m = 1'b0;
`endif
      #1;
      check_outputs(tag);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 3 * MAX_DEPTH; i++) begin
         if (q.size() == 0) break;
         step(1'b1, 1'b0, 1'b0, 24'hABCABC, 1'b0, '0, tag);
      end
      chk({tag, ".drained"}, 32'(empty_o), 32'd1);
   endtask

   initial begin
      int first_k;
      int peak;
      logic [CW-1:0] cnt_hold;

      rst_n = 1'b0; en_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
      data_i = '0; depth_ld_i = 1'b0; depth_sel_i = '0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // contiguous burst at full depth
      first_k = -1;
      peak    = 0;
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b0, 1'b1, mk(k), 1'b0, '0, "burst");
         if (valid_o === 1'b1 && first_k < 0) first_k = k;
         if (int'(cnt_o) > peak) peak = int'(cnt_o);
      end
      chk("burst.latency", 32'(first_k - 1), 32'(MAX_DEPTH - 1));
      chk("burst.cnt_peak", 32'(peak), 32'(MAX_DEPTH));
      drain("burst_drain");

      // burst with a 3-cycle stall in the middle
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b0, 1'b1, mk(k + 16), 1'b0, '0, "stall_burst");
         if (k == 4) begin
            cnt_hold = cnt_o;
            for (int s = 0; s < 3; s++) begin
               step(1'b0, 1'b0, 1'b1, mk(99), 1'b0, '0, "stall");
               chk("stall.cnt_hold", 32'(cnt_o), 32'(cnt_hold));
            end
         end
      end
      drain("stall_drain");

      // sparse valids with live data on invalid cycles
      for (int k = 40; k < 52; k++) step(1'b1, 1'b0, 1'(k % 2), mk(k), 1'b0, '0, "sparse");
      drain("sparse_drain");

      // flush with five words inside, while stalled and offering a word
      for (int k = 60; k < 65; k++) step(1'b1, 1'b0, 1'b1, mk(k), 1'b0, '0, "pre_flush");
      chk("pre_flush.cnt5", 32'(cnt_o), 32'd5);
      step(1'b0, 1'b1, 1'b1, mk(77), 1'b0, '0, "flush");
      chk("flush.cnt0", 32'(cnt_o), 32'd0);
      for (int i = 0; i < MAX_DEPTH + 2; i++) step(1'b1, 1'b0, 1'b0, mk(i), 1'b0, '0, "post_flush");

`ifdef DELAY_PIPE_V_DEPTH_SEL_EN
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, CW'(3), "ld3");
      chk("ld3.depth", 32'(depth_o), 32'd3);
      step(1'b1, 1'b0, 1'b1, mk(200), 1'b0, '0, "d3_push");
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, "d3_wait");
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, "d3_wait");
      chk("d3.latency", 32'(valid_o), 32'd1);
      drain("d3_drain");
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, CW'(0), "ld_sel0");
      chk("ld_sel0.err", 32'(depth_err_o), 32'd1);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, "ld_sel0_after");
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, CW'(9), "ld_sel9");
      chk("ld_sel9.err", 32'(depth_err_o), 32'd1);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, "ld_sel9_after");
      step(1'b1, 1'b0, 1'b1, mk(210), 1'b0, '0, "busy_push");
      step(1'b1, 1'b0, 1'b1, mk(211), 1'b0, '0, "busy_push");
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, CW'(5), "ld_busy");
      chk("ld_busy.depth", 32'(depth_o), 32'd3);
      step(1'b0, 1'b1, 1'b0, '0, 1'b1, CW'(5), "ld_flush");
      chk("ld_flush.depth", 32'(depth_o), 32'd5);
      for (int k = 220; k < 224; k++) step(1'b1, 1'b0, 1'b1, mk(k), 1'b0, '0, "d5_burst");
      drain("d5_drain");
`else
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, CW'(3), "ld_ignored");
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, CW'(0), "ld_ignored0");
      for (int k = 230; k < 233; k++) step(1'b1, 1'b0, 1'b1, mk(k), 1'b1, CW'(2), "ld_ignored_burst");
      drain("ld_ignored_drain");
`endif

      // asynchronous reset between edges with words in flight
      for (int k = 240; k <= 240 + depth_m; k++) step(1'b1, 1'b0, 1'b1, mk(k), 1'b0, '0, "pre_rst");
      chk("pre_rst.valid", 32'(valid_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.valid", 32'(valid_o), 32'd0);
      chk("arst.data",  32'(data_o),  32'd0);
      chk("arst.cnt",   32'(cnt_o),   32'd0);
      chk("arst.empty", 32'(empty_o), 32'd1);
      chk("arst.depth", 32'(depth_o), 32'(MAX_DEPTH));
      chk("arst.err",   32'(depth_err_o), 32'd0);
      q.delete();
      depth_m = MAX_DEPTH;
      err_m   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b1, mk(250), 1'b0, '0, "post_rst");
      drain("post_rst_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
